if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage sitting directly upstream of the combinational instruction ROM. It owns the program counter and drives the ROM byte address. It captures the returned instruction word into the IF/ID pipeline register consumed by decode. It handles stall, redirect (branch/jump flush) and a halt-on-sentinel condition used to end test programs.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- MEM_WORDS, 1042, number of 32-bit words in the instruction ROM; used only by the bound check
- HALT_INSTR, 32'h0010_0073 (ebreak), instruction word that stops fetch
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold PC and IF/ID register this cycle
- redirect_valid  input  1  load redirect_pc and flush IF/ID
- redirect_pc  input  32  redirect target byte address
- imem_addr  output  32  byte address to ROM; combinationally equal to pc_q
- imem_rdata  input  32  instruction word from ROM, combinational from imem_addr
- id_valid  output  1  IF/ID slot holds a real instruction
- id_pc  output  32  PC of id_instr
- id_instr  output  32  captured instruction; NOP when invalid
- halted  output  1  fetch has stopped (HALT state)
- id_exc  output  1  fetch fault flag (only with IF_BOUND_CHK_EN; else tied 0)

## Operation
- Two-state FSM: RUN, HALT.
- Reset values: pc_q=RESET_PC, state=RUN, id_valid=0, id_pc=0, id_instr=32'h0000_0013 (NOP), halted=0, id_exc=0.
- RUN, per rising edge, in priority order:
  - redirect_valid=1: pc_q<=redirect_pc; id_valid<=0; id_instr<=NOP. Redirect overrides stall.
  - stall=1: all registers hold.
  - otherwise: id_pc<=pc_q; id_instr<=imem_rdata; id_valid<=1; pc_q<=pc_q+4.
  - If the captured word equals HALT_INSTR, it is still delivered with id_valid=1. In the same edge, state<=HALT and pc_q holds instead of incrementing.
- HALT:
  - pc_q frozen; halted=1 (registered; asserts the cycle after the HALT_INSTR capture).
  - Redirects are ignored.
  - When stall=0: id_valid<=0 and id_instr<=NOP, producing bubbles. When stall=1: registers hold.
  - Only rst_n exits HALT.
- Arithmetic: pc_q+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. No alignment forcing; redirect_pc is loaded as given.

## Timing
- ROM path is combinational: imem_addr = pc_q; imem_rdata is sampled on the same edge.
- Fetch latency: one cycle from PC to id_instr/id_valid.
- After rst_n rises, the first edge captures the word at RESET_PC.
- Stall on cycle n: outputs at n+1 equal those at n.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clk.

## Configuration
- IF_BOUND_CHK_EN defined: on an unstalled RUN capture, a fault is raised if pc_q[1:0]!=0, pc_q<RESET_PC, or pc_q>=RESET_PC+4*MEM_WORDS. On a fault:
  - id_instr<=NOP, id_valid<=1, id_exc<=1, state<=HALT.
  - id_exc is sticky until reset.
- IF_BOUND_CHK_EN undefined: no check; id_exc is constant 0; out-of-range addresses are passed to the ROM unchanged.

## Structure
- Shared package if_pkg: NOP_INSTR, default HALT_INSTR, default RESET_PC, FSM state enum {RUN, HALT}.
- One sub-module, if_pc_reg: PC register with next-PC mux (redirect / hold / +4) and reset load of RESET_PC. IF/ID register and FSM live in the top.

## Test plan
- Reset release with ROM words 0x3000: addi, 0x3004: add, 0x3008: ebreak:
  - id_instr sequence addi, add, ebreak with id_pc 0x3000, 0x3004, 0x3008.
  - halted=1 next cycle; then id_valid=0 and imem_addr stays 0x3008.
- stall=1 for 3 cycles mid-stream: id_pc, id_instr, imem_addr unchanged across those cycles; the sequence resumes without skipping or duplicating a word.
- redirect_valid=1 with redirect_pc=0x3040 and stall=1 in the same cycle: next cycle imem_addr=0x3040, id_valid=0; the following cycle id_pc=0x3040.
- In HALT, redirect_valid=1 to 0x3000: no effect; then assert rst_n=0 asynchronously between edges: imem_addr=0x3000, halted=0 before the next clk edge.
- With IF_BOUND_CHK_EN, redirect to 0x3002: next capture gives id_exc=1, id_instr=NOP, halted=1 the cycle after.
- With IF_BOUND_CHK_EN, fall-through to 0x3000+4*1042: same fault.
- Without the macro, the same stimulus gives id_exc=0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared constants and FSM state type for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [31:0] HALT_INSTR_DEF = 32'h0010_0073;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam int          MEM_WORDS_DEF  = 1042;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction ROM bus between the fetch stage (master) and the ROM (slave).
// The ROM is combinational: imem_rdata reflects imem_addr within the same cycle and
// there is no valid/ready handshake; the fetch stage samples imem_rdata on its clock edge.
interface if_fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_pc_reg.sv
// Program counter with next-PC mux: load (redirect) > hold > increment by 4.
module if_pc_reg
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        hold,
    input  logic [31:0] load_pc,
    output logic [31:0] pc_q
);

    logic [31:0] pc_d;

    always_comb begin
        if (load)      pc_d = load_pc;
        else if (hold) pc_d = pc_q;
        else           pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register and RUN/HALT FSM.
// Optional fetch bound check enabled by defining IF_BOUND_CHK_EN.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          MEM_WORDS  = MEM_WORDS_DEF,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    if_fetch_stage_if.master    imem,
    output logic                id_valid,
    output logic [31:0]         id_pc,
    output logic [31:0]         id_instr,
    output logic                halted,
    output logic                id_exc,
    output state_t              state_dbg
);

`ifdef IF_BOUND_CHK_EN
    localparam bit BOUND_CHK = 1'b1;
`else
    localparam bit BOUND_CHK = 1'b0;
`endif

    // 33-bit end address so a ROM ending at the top of memory does not wrap.
    localparam logic [32:0] PC_END = {1'b0, RESET_PC} + 33'(MEM_WORDS) * 33'd4;

    state_t      state;
    logic [31:0] pc_q;
    logic        exc_q;
    logic        run;
    logic        capture;
    logic        is_halt;
    logic        fault;
    logic        pc_hold;

    assign run     = (state == RUN);
    assign capture = run && !redirect_valid && !stall;
    assign is_halt = (imem.imem_rdata == HALT_INSTR);
    assign fault   = BOUND_CHK && ((pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) ||
                                   ({1'b0, pc_q} >= PC_END));
    // PC freezes on the capture that ends fetch, and stays frozen in HALT.
    assign pc_hold = !run || stall || (capture && (is_halt || fault));

    if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (run && redirect_valid),
        .hold    (pc_hold),
        .load_pc (redirect_pc),
        .pc_q    (pc_q)
    );

    assign imem.imem_addr = pc_q;
    assign id_exc         = BOUND_CHK ? exc_q : 1'b0;
    assign state_dbg      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            id_valid <= 1'b0;
            id_pc    <= 32'h0;
            id_instr <= NOP_INSTR;
            halted   <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        id_valid <= 1'b0;
                        id_instr <= NOP_INSTR;
                    end else if (!stall) begin
                        id_pc    <= pc_q;
                        id_valid <= 1'b1;
                        if (fault) begin
                            id_instr <= NOP_INSTR;
                            exc_q    <= 1'b1;
                            state    <= HALT;
                            halted   <= 1'b1;
                        end else begin
                            id_instr <= imem.imem_rdata;
                            if (is_halt) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end
                        end
                    end
                end
                HALT: begin
                    if (!stall) begin
                        id_valid <= 1'b0;
                        id_instr <= NOP_INSTR;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed test-plan scenarios plus a
// randomized stall/redirect phase against a transaction-level fetch model.
module tb_if_fetch_stage;
  import if_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          WORDS  = 1042;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] ADD    = 32'h0020_81b3;

`ifdef IF_BOUND_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid, halted, id_exc;
  logic [31:0] id_pc, id_instr;
  state_t      state_dbg;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus.master),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .halted         (halted),
    .id_exc         (id_exc),
    .state_dbg      (state_dbg)
  );

  // ROM contents; addresses outside it return a recognisable non-halt pattern
  logic [31:0] rom_mem [WORDS];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(RST_PC);
    if (a[1:0] == 2'b00 && off >= 0 && off < 4 * WORDS) return rom_mem[int'(off / 4)];
    return {a[15:0], 16'h5a5a};
  endfunction

  assign imem_bus.imem_rdata = rom_word(imem_bus.imem_addr);

  // scoreboard
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: architectural view of the fetch stage
  logic [31:0] m_pc, m_id_pc, m_instr;
  bit          m_valid, m_halt, m_exc;

  function automatic bit out_of_bounds(input logic [31:0] a);
    longint lo, hi;
    lo = longint'(RST_PC);
    hi = lo + 4 * WORDS;
    return (a % 4 != 0) || longint'(a) < lo || longint'(a) >= hi;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_id_pc = 32'h0; m_instr = NOP_INSTR;
    m_valid = 0; m_halt = 0; m_exc = 0;
  endtask

  task automatic model_edge(input bit s, input bit r, input logic [31:0] rpc);
    logic [31:0] w;
    if (!m_halt) begin
      if (r) begin
        m_pc = rpc; m_valid = 0; m_instr = NOP_INSTR;
      end else if (!s) begin
        w = rom_word(m_pc);
        m_id_pc = m_pc;
        m_valid = 1;
        if (CHK && out_of_bounds(m_pc)) begin
          m_instr = NOP_INSTR; m_exc = 1; m_halt = 1;
        end else begin
          m_instr = w;
          if (w == EBREAK) m_halt = 1;
          else m_pc = m_pc + 32'd4;
        end
      end
    end else if (!s) begin
      m_valid = 0; m_instr = NOP_INSTR;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".addr"},   imem_bus.imem_addr, m_pc);
    check({tag, ".valid"},  32'(id_valid), 32'(m_valid));
    check({tag, ".id_pc"},  id_pc, m_id_pc);
    check({tag, ".instr"},  id_instr, m_instr);
    check({tag, ".halted"}, 32'(halted), 32'(m_halt));
    check({tag, ".exc"},    32'(id_exc), 32'(m_exc));
  endtask

  // driver: called at negedge, applies inputs across one rising edge
  task automatic step(input bit s, input bit r, input logic [31:0] rpc, input string tag);
    stall = s; redirect_valid = r; redirect_pc = rpc;
    @(posedge clk);
    model_edge(s, r, rpc);
    #1;
    compare_all(tag);
    @(negedge clk);
    stall = 0; redirect_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic fill_rom_random();
    logic [31:0] v;
    for (int i = 0; i < WORDS; i++) begin
      v = $urandom;
      if (v == EBREAK) v = v + 1;
      rom_mem[i] = v;
    end
  endtask

  logic [31:0] sv_pc, sv_instr, sv_addr;

  initial begin
    // reset release into a three-instruction program
    fill_rom_random();
    rom_mem[0] = ADDI; rom_mem[1] = ADD; rom_mem[2] = EBREAK;
    model_reset();
    #12;
    @(negedge clk);
    do_reset();
    step(0, 0, 0, "prog0");
    check("prog0_instr", id_instr, ADDI);
    check("prog0_pc", id_pc, 32'h3000);
    step(0, 0, 0, "prog1");
    check("prog1_instr", id_instr, ADD);
    check("prog1_pc", id_pc, 32'h3004);
    step(0, 0, 0, "prog2");
    check("prog2_instr", id_instr, EBREAK);
    check("prog2_pc", id_pc, 32'h3008);
    check("prog2_valid", 32'(id_valid), 32'd1);
    step(0, 0, 0, "halt_bubble");
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_valid", 32'(id_valid), 32'd0);
    check("halt_addr", imem_bus.imem_addr, 32'h3008);
    step(0, 1, 32'h3000, "halt_redirect");
    check("halt_redirect_addr", imem_bus.imem_addr, 32'h3008);
    // asynchronous reset between edges
    #2;
    rst_n = 0;
    #1;
    check("async_rst_addr", imem_bus.imem_addr, 32'h3000);
    check("async_rst_halted", 32'(halted), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // stall for three cycles mid-stream
    fill_rom_random();
    do_reset();
    step(0, 0, 0, "s_run0");
    step(0, 0, 0, "s_run1");
    sv_pc = id_pc; sv_instr = id_instr; sv_addr = imem_bus.imem_addr;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, "stall");
      check("stall_id_pc", id_pc, sv_pc);
      check("stall_instr", id_instr, sv_instr);
      check("stall_addr", imem_bus.imem_addr, sv_addr);
    end
    step(0, 0, 0, "s_resume");
    check("resume_pc", id_pc, sv_pc + 32'd4);
    check("resume_instr", id_instr, rom_mem[(sv_pc + 32'd4 - RST_PC) >> 2]);

    // redirect overrides stall
    step(1, 1, 32'h3040, "redir_stall");
    check("redir_addr", imem_bus.imem_addr, 32'h3040);
    check("redir_valid", 32'(id_valid), 32'd0);
    step(0, 0, 0, "redir_next");
    check("redir_id_pc", id_pc, 32'h3040);

    // misaligned redirect target
    do_reset();
    step(0, 1, 32'h3002, "mis_redir");
    step(0, 0, 0, "mis_capture");
    check("mis_exc", 32'(id_exc), 32'(CHK));
    check("mis_halted", 32'(halted), 32'(CHK));
    step(0, 0, 0, "mis_after");

    // fall-through past the end of the ROM
    do_reset();
    step(0, 1, RST_PC + 32'(4 * (WORDS - 1)), "end_redir");
    step(0, 0, 0, "end_last");
    check("end_last_exc", 32'(id_exc), 32'd0);
    step(0, 0, 0, "end_over");
    check("end_over_exc", 32'(id_exc), 32'(CHK));
    step(0, 0, 0, "end_after");

    // 32-bit wrap of the PC increment
    do_reset();
    step(0, 1, 32'hFFFF_FFFC, "wrap_redir");
    step(0, 0, 0, "wrap_capture");

    // randomized stall / redirect traffic with a few planted halts
    fill_rom_random();
    for (int k = 0; k < 4; k++) rom_mem[$urandom_range(8, WORDS - 1)] = EBREAK;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [31:0] tgt;
      bit s, r;
      if (m_halt && $urandom_range(0, 7) == 0) do_reset();
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 9))
        0:       tgt = $urandom;
        1:       tgt = RST_PC + 32'(4 * WORDS) - 32'd4;
        default: tgt = RST_PC + 32'(4 * $urandom_range(0, WORDS - 1));
      endcase
      step(s, r, tgt, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog keeps the run bounded even if a step never returns
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
